// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core load/store
// path and the host (preload/readback) port. Each access runs IDLE -> XFER -> ACK.
// The winner's address/data/we are latched on grant and presented to the memory
// during XFER; load data is captured at the end of XFER and returned with a
// one-cycle ack in ACK.
// Optional feature: define PEBBLE_DMEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests (default build: fixed priority, core over host).
module dmem_arbiter #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic [DW-1:0] core_rdata,
   output logic          core_ack,
   output logic          core_stall,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic [DW-1:0] host_rdata,
   output logic          host_ack,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic          sel_host_s;
   logic          gnt_host_r;
   logic          last_host_r;
   logic          we_r;
   logic [AW-1:0] mem_addr_r;
   logic [DW-1:0] mem_wdata_r;
   logic [DW-1:0] core_rdata_r;
   logic [DW-1:0] host_rdata_r;
   logic          core_ack_r;
   logic          host_ack_r;
   logic          mem_we_s;
   logic          busy_s;

   // Pick the port to grant when the FSM is idle.
   always_comb begin
      sel_host_s = 1'b0;
      if (core_req && host_req) begin
`ifdef PEBBLE_DMEM_ARB_RR_EN
         // Alternate: the port that was not served last wins.
         sel_host_s = ~last_host_r;
`else
         // Fixed priority: core always wins a tie.
         sel_host_s = 1'b0;
`endif
      end else if (host_req) begin
         sel_host_s = 1'b1;
      end else begin
         sel_host_s = 1'b0;
      end
   end

   // FSM state register; async reset drops the FSM (and so mem_we) immediately.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; a request still high during ACK is seen in the next IDLE.
   always_comb begin
      state_nxt_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (core_req || host_req) begin
               state_nxt_s = ST_XFER;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_XFER: state_nxt_s = ST_ACK;
         ST_ACK:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM outputs: the memory write strobe exists only in XFER.
   always_comb begin
      mem_we_s = 1'b0;
      busy_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            mem_we_s = 1'b0;
            busy_s   = 1'b0;
         end
         ST_XFER: begin
            mem_we_s = we_r;
            busy_s   = 1'b1;
         end
         ST_ACK: begin
            mem_we_s = 1'b0;
            busy_s   = 1'b1;
         end
         default: begin
            mem_we_s = 1'b0;
            busy_s   = 1'b0;
         end
      endcase
   end

   // Grant capture: latch the winner's request fields so XFER sees stable values.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         gnt_host_r  <= 1'b0;
         we_r        <= 1'b0;
         mem_addr_r  <= {AW{1'b0}};
         mem_wdata_r <= {DW{1'b0}};
      end else if ((state_r == ST_IDLE) && (core_req || host_req)) begin
         gnt_host_r  <= sel_host_s;
         we_r        <= sel_host_s ? host_we    : core_we;
         mem_addr_r  <= sel_host_s ? host_addr  : core_addr;
         mem_wdata_r <= sel_host_s ? host_wdata : core_wdata;
      end else begin
         gnt_host_r  <= gnt_host_r;
         we_r        <= we_r;
         mem_addr_r  <= mem_addr_r;
         mem_wdata_r <= mem_wdata_r;
      end
   end

   // Load data capture at the end of XFER; stores leave the rdata register untouched.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         core_rdata_r <= {DW{1'b0}};
         host_rdata_r <= {DW{1'b0}};
      end else if ((state_r == ST_XFER) && !we_r) begin
         if (gnt_host_r) begin
            host_rdata_r <= mem_rdata;
         end else begin
            core_rdata_r <= mem_rdata;
         end
      end else begin
         core_rdata_r <= core_rdata_r;
         host_rdata_r <= host_rdata_r;
      end
   end

   // Ack pulses (high exactly while in ACK) and round-robin history update.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         core_ack_r  <= 1'b0;
         host_ack_r  <= 1'b0;
         last_host_r <= 1'b0;
      end else begin
         core_ack_r <= (state_r == ST_XFER) && !gnt_host_r;
         host_ack_r <= (state_r == ST_XFER) &&  gnt_host_r;
         if (state_r == ST_ACK) begin
            last_host_r <= gnt_host_r;
         end else begin
            last_host_r <= last_host_r;
         end
      end
   end

   assign core_rdata = core_rdata_r;
   assign host_rdata = host_rdata_r;
   assign core_ack   = core_ack_r;
   assign host_ack   = host_ack_r;
   assign core_stall = core_req && !core_ack_r;
   assign mem_addr   = mem_addr_r;
   assign mem_wdata  = mem_wdata_r;
   assign mem_we     = mem_we_s;
   assign busy       = busy_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven single-port accesses with a
// scoreboard queue of expected ack/rdata, plus hand-written contention,
// dropped-request and reset-during-write sequences.
module tb_dmem_arbiter;

   logic       Clk;
   logic       Reset;
   logic       core_req, core_we, host_req, host_we;
   logic [7:0] core_addr, core_wdata, host_addr, host_wdata;
   logic [7:0] core_rdata, host_rdata;
   logic       core_ack, core_stall, host_ack;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_we, busy;

   logic [7:0] tb_mem [0:255];

   int checks   = 0;
   int failures = 0;
   logic m_last_host = 1'b0;

   typedef struct {
      logic       host;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic       host;
      logic [7:0] rdata;
   } sb_t;

   vec_t vecs [11];
   sb_t  sb_q [$];

   dmem_arbiter #(.DW(8), .AW(8)) dut (
      .Clk(Clk), .Reset(Reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ack(core_ack),
      .core_stall(core_stall),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Behavioural single-port memory: combinational read, synchronous write.
   always @(posedge Clk) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = tb_mem[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One access from a single requester; checks latency, write strobe, ack and rdata.
   task automatic access(input logic h, input logic we, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rd);
      int   cyc;
      int   we_cnt;
      logic got;
      sb_t  e;
      @(negedge Clk);
      if (h) begin
         host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
      end else begin
         core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
      end
      sb_q.push_back('{h, exp_rd});
      got = 1'b0; cyc = 0; we_cnt = 0;
      while (!got && cyc < 10) begin
         @(negedge Clk);
         cyc++;
         if (mem_we) begin
            we_cnt++;
            chk("wr_addr", {24'd0, mem_addr}, {24'd0, a});
            chk("wr_data", {24'd0, mem_wdata}, {24'd0, d});
         end
         if (core_ack || host_ack) got = 1'b1;
      end
      chk("ack_seen", {31'd0, got}, 32'd1);
      e = sb_q.pop_front();
      if (got) begin
         chk("ack_latency", cyc, 32'd2);
         chk("ack_port", {31'd0, host_ack}, {31'd0, e.host});
         chk("ack_exclusive", {31'd0, core_ack & host_ack}, 32'd0);
         chk("rdata", {24'd0, (e.host ? host_rdata : core_rdata)}, {24'd0, e.rdata});
         m_last_host = h;
      end
      core_req = 1'b0; host_req = 1'b0;
      @(negedge Clk);
      chk("ack_pulse_width", {31'd0, core_ack | host_ack}, 32'd0);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("we_count", we_cnt, {31'd0, we});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic win;
      logic exp_ack;
      for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;

      // host/we/addr/wdata/expected rdata of that port after the ack
      vecs[0]  = '{1'b1, 1'b1, 8'h05, 8'hA7, 8'h00};
      vecs[1]  = '{1'b1, 1'b1, 8'h1F, 8'h5C, 8'h00};
      vecs[2]  = '{1'b0, 1'b0, 8'h05, 8'h00, 8'hA7};
      vecs[3]  = '{1'b0, 1'b0, 8'h1F, 8'h00, 8'h5C};
      vecs[4]  = '{1'b1, 1'b0, 8'h05, 8'h00, 8'hA7};
      vecs[5]  = '{1'b0, 1'b1, 8'h80, 8'h3C, 8'h5C};
      vecs[6]  = '{1'b1, 1'b0, 8'h80, 8'h00, 8'h3C};
      vecs[7]  = '{1'b0, 1'b1, 8'hFF, 8'h01, 8'h5C};
      vecs[8]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h01};
      vecs[9]  = '{1'b1, 1'b1, 8'h00, 8'hE2, 8'h3C};
      vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hE2};

      Reset = 1'b0;
      core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
      host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
      repeat (2) @(negedge Clk);
      chk("rst_core_ack", {31'd0, core_ack}, 32'd0);
      chk("rst_host_ack", {31'd0, host_ack}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_core_rdata", {24'd0, core_rdata}, 32'd0);
      chk("rst_host_rdata", {24'd0, host_rdata}, 32'd0);
      chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      Reset = 1'b1;

      for (int i = 0; i < 11; i++) begin
         access(vecs[i].host, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
      end

      // Both ports request continuously: one ack every 3 cycles.
      @(negedge Clk);
      core_req = 1'b1; core_we = 1'b0; core_addr = 8'h05;
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h1F;
      for (int k = 1; k <= 11; k++) begin
         @(negedge Clk);
         exp_ack = ((k % 3) == 2);
`ifdef PEBBLE_DMEM_ARB_RR_EN
         win = ~m_last_host;
`else
         win = 1'b0;
`endif
         chk("both_core_ack", {31'd0, core_ack}, {31'd0, exp_ack & ~win});
         chk("both_host_ack", {31'd0, host_ack}, {31'd0, exp_ack & win});
         chk("both_core_stall", {31'd0, core_stall}, {31'd0, ~(exp_ack & ~win)});
         if (exp_ack) begin
            if (win) chk("both_host_rdata", {24'd0, host_rdata}, 32'h5C);
            else     chk("both_core_rdata", {24'd0, core_rdata}, 32'hA7);
            m_last_host = win;
         end
         if (k == 11) begin
            core_req = 1'b0; host_req = 1'b0;
         end
      end
      @(negedge Clk);
      chk("both_idle", {31'd0, busy}, 32'd0);

      // Request dropped during XFER: the access still completes and acks.
      @(negedge Clk);
      core_req = 1'b1; core_we = 1'b0; core_addr = 8'h80;
      @(negedge Clk);
      core_req = 1'b0;
      chk("drop_busy", {31'd0, busy}, 32'd1);
      @(negedge Clk);
      chk("drop_ack", {31'd0, core_ack}, 32'd1);
      chk("drop_rdata", {24'd0, core_rdata}, 32'h3C);
      m_last_host = 1'b0;
      @(negedge Clk);
      chk("drop_ack_low", {31'd0, core_ack}, 32'd0);

      // Reset asserted during a host write in XFER.
      @(negedge Clk);
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h99;
      @(negedge Clk);
      chk("rstx_we_before", {31'd0, mem_we}, 32'd1);
      Reset = 1'b0;
      #1;
      chk("rstx_we_async", {31'd0, mem_we}, 32'd0);
      chk("rstx_busy", {31'd0, busy}, 32'd0);
      chk("rstx_core_rdata", {24'd0, core_rdata}, 32'd0);
      chk("rstx_host_rdata", {24'd0, host_rdata}, 32'd0);
      chk("rstx_mem_addr", {24'd0, mem_addr}, 32'd0);
      host_req = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      m_last_host = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         chk("rstx_no_ack", {31'd0, host_ack | core_ack}, 32'd0);
         chk("rstx_idle", {31'd0, busy}, 32'd0);
      end
      chk("rstx_mem_untouched", {24'd0, tb_mem[8'h40]}, 32'd0);
      access(1'b0, 1'b0, 8'h40, 8'h00, 8'h00);
      access(1'b0, 1'b0, 8'h1F, 8'h00, 8'h5C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
